// File: rtl/rf_writeback.sv
// Register-file writeback queue: merges ALU and load results into a small FIFO
// that drains one register write per cycle and exposes queued data for bypass.
module rf_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ALU_VALID,
    input  logic [4:0]                 ALU_RD,
    input  logic [31:0]                ALU_DATA,
    output logic                       ALU_READY,
    input  logic                       MEM_VALID,
    input  logic [4:0]                 MEM_RD,
    input  logic [31:0]                MEM_DATA,
    output logic                       MEM_READY,
    output logic [4:0]                 WNUM,
    output logic [31:0]                WDATA,
    input  logic [4:0]                 RNUM1,
    input  logic [4:0]                 RNUM2,
    output logic                       FWD1_HIT,
    output logic                       FWD2_HIT,
    output logic [31:0]                FWD1_DATA,
    output logic [31:0]                FWD2_DATA,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       FULL,
    output logic                       EMPTY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_alu_hs;
    logic          w_mem_hs;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_push_rd;
    logic [31:0]   w_push_data;
    logic [32:0]   w_fwd1;
    logic [32:0]   w_fwd2;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    assign ALU_READY = !w_full;
    assign MEM_READY = !w_full && !ALU_VALID;

    assign w_alu_hs    = ALU_VALID && ALU_READY;
    assign w_mem_hs    = MEM_VALID && MEM_READY;
    assign w_push_rd   = w_alu_hs ? ALU_RD : MEM_RD;
    assign w_push_data = w_alu_hs ? ALU_DATA : MEM_DATA;
    // Writes to x0 complete the handshake but are never queued.
    assign w_push      = (w_alu_hs || w_mem_hs) && (w_push_rd != 5'd0);
    assign w_pop       = !w_empty;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_rd[r_wptr]   <= w_push_rd;
            r_data[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walks oldest to youngest so the last match wins: {hit, data}.
    function automatic logic [32:0] f_lookup(input logic [4:0] rnum);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + AW'(i);
            if ((CW'(i) < r_count) && (rnum != 5'd0) && (r_rd[idx] == rnum))
                res = {1'b1, r_data[idx]};
        end
        return res;
    endfunction

    always_comb begin
        w_fwd1 = f_lookup(RNUM1);
        w_fwd2 = f_lookup(RNUM2);
    end

    assign FWD1_HIT  = w_fwd1[32];
    assign FWD1_DATA = w_fwd1[31:0];
    assign FWD2_HIT  = w_fwd2[32];
    assign FWD2_DATA = w_fwd2[31:0];

    assign WNUM  = w_empty ? 5'd0  : r_rd[r_rptr];
    assign WDATA = w_empty ? 32'd0 : r_data[r_rptr];

    assign COUNT = r_count;
    assign FULL  = w_full;
    assign EMPTY = w_empty;

endmodule
